// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous circular FIFO.
// Brings the Gray write pointer into the read domain through two flops, derives
// empty and fill level from it, and feeds the consumer through a registered
// first-word-fall-through stage that can take one word per cycle.
module fifo_read_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 5
) (
  input  logic                 r_clk,
  input  logic                 r_rstn,
  input  logic [PTR_WIDTH-1:0] wptr_gray_in,
  input  logic [WIDTH-1:0]     data_read_in,
  input  logic                 ready_in,
  output logic [PTR_WIDTH-1:0] read_ptr_out,
  output logic [PTR_WIDTH-1:0] rptr_gray_out,
  output logic                 read_out,
  output logic                 empty_out,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  output logic [PTR_WIDTH-1:0] rd_count_out
);

  // The memory address is the pointer without its wrap bit, so the depth must
  // be exactly half the pointer range.
  if (DEPTH != (1 << (PTR_WIDTH - 1))) begin : g_depth_check
    $error("fifo_read_ctrl: DEPTH must equal 2**(PTR_WIDTH-1)");
  end

  logic [PTR_WIDTH-1:0] wq1;
  logic [PTR_WIDTH-1:0] wq2;
  logic [PTR_WIDTH-1:0] rbin;
  logic [PTR_WIDTH-1:0] rgray;
  logic [PTR_WIDTH-1:0] wbin;
  logic [PTR_WIDTH-1:0] rbin_next;
  logic                 pop;

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pointer comparison and pop decision, all taken from registered state.
  always_comb begin
    wbin      = gray2bin(wq2);
    rbin_next = rbin + 1'b1;
    empty_out = (rgray == wq2);
    pop       = !empty_out && (!valid_out || ready_in);
  end

  assign read_out      = pop;
  assign read_ptr_out  = rbin;
  assign rptr_gray_out = rgray;
  // Modulo subtraction naturally yields DEPTH when only the wrap bits differ.
  assign rd_count_out  = wbin - rbin;

  // Write-pointer synchronizer: plain back-to-back flops, nothing in between.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wptr_gray_in;
      wq2 <= wq1;
    end
  end

  // Read pointer and output stage; a pop on an accept cycle overwrites the
  // accepted word so valid stays high and throughput is one word per cycle.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      rbin      <= '0;
      rgray     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (pop) begin
      rbin      <= rbin_next;
      rgray     <= rbin_next ^ (rbin_next >> 1);
      data_out  <= data_read_in;
      valid_out <= 1'b1;
    end else if (valid_out && ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: the bench plays the write side and
// the FIFO memory, a scoreboard queue holds words in write order, and a
// negedge monitor compares every consumer transfer against it.
module tb_fifo_read_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int PW    = 5;

  logic             r_clk = 1'b0;
  logic             r_rstn;
  logic [PW-1:0]    wptr_gray_in;
  logic [WIDTH-1:0] data_read_in;
  logic             ready_in;
  logic [PW-1:0]    read_ptr_out;
  logic [PW-1:0]    rptr_gray_out;
  logic             read_out;
  logic             empty_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic [PW-1:0]    rd_count_out;

  fifo_read_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
    .r_clk(r_clk), .r_rstn(r_rstn), .wptr_gray_in(wptr_gray_in),
    .data_read_in(data_read_in), .ready_in(ready_in), .read_ptr_out(read_ptr_out),
    .rptr_gray_out(rptr_gray_out), .read_out(read_out), .empty_out(empty_out),
    .data_out(data_out), .valid_out(valid_out), .rd_count_out(rd_count_out)
  );

  always #5 r_clk = ~r_clk;

  logic [WIDTH-1:0] mem [DEPTH];
  assign data_read_in = mem[read_ptr_out[PW-2:0]];

  int checks = 0;
  int errors = 0;
  int w = 0;  // words written since reset
  int d = 0;  // words delivered to the consumer since reset
  logic [WIDTH-1:0] exp_q[$];
  logic [PW-1:0] prev_rg = '0;
  logic [PW-1:0] prev_rp = '0;
  bit saw_wrap = 1'b0;

  function automatic logic [PW-1:0] gray(input int x);
    logic [PW-1:0] b;
    b = PW'(x);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] v);
    mem[w % DEPTH] = v;
    w++;
    exp_q.push_back(v);
    wptr_gray_in = gray(w);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!valid_out && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!valid_out) begin
      errors++;
      $display("FAIL wait_valid: valid_out still %0d after %0d cycles", valid_out, n);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each transfer.
  always @(negedge r_clk) begin
    if (!r_rstn) begin
      prev_rg = '0;
      prev_rp = '0;
    end else begin
      checks++;
      if (int'(rd_count_out) + int'(valid_out) > w - d) begin
        errors++;
        $display("FAIL count_overstates: rd_count %0d valid %0d true %0d", rd_count_out, valid_out, w - d);
      end
      if (read_out) begin
        checks++;
        if (w - d - int'(valid_out) < 1) begin
          errors++;
          $display("FAIL pop_when_empty: read_out %0d with memory occupancy %0d", read_out, w - d - int'(valid_out));
        end
      end
      if (rptr_gray_out != prev_rg) begin
        checks++;
        if ($countones(rptr_gray_out ^ prev_rg) != 1 || rptr_gray_out != gray(int'(read_ptr_out))) begin
          errors++;
          $display("FAIL gray_step: got %b from %b, read_ptr %0d needs %b", rptr_gray_out, prev_rg, read_ptr_out, gray(int'(read_ptr_out)));
        end
      end
      if (prev_rp == PW'(31) && read_ptr_out == '0) saw_wrap = 1'b1;
      prev_rg = rptr_gray_out;
      prev_rp = read_ptr_out;
      if (valid_out && ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h with empty scoreboard", data_out);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          if (data_out != e) begin
            errors++;
            $display("FAIL data_order: got %h expected %h", data_out, e);
          end
        end
        d++;
      end
    end
  end

  initial begin
    int n;
    logic [WIDTH-1:0] b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ready_in     = 1'b0;
    r_rstn       = 1'b0;
    // Two words present while held in reset.
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    w = 2;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    wptr_gray_in = 5'b00011;
    repeat (3) tick();
    chk("rst_valid", valid_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_read", read_out, 0);
    chk("rst_rptr", read_ptr_out, 0);
    chk("rst_rgray", rptr_gray_out, 0);
    chk("rst_count", rd_count_out, 0);
    chk("rst_data", data_out, 0);
    r_rstn = 1'b1;
    tick();
    chk("rel_e0_empty", empty_out, 1);
    chk("rel_e0_read", read_out, 0);
    tick();
    chk("rel_e1_empty", empty_out, 0);
    chk("rel_e1_read", read_out, 1);
    chk("rel_e1_count", rd_count_out, 2);
    tick();
    chk("rel_e2_valid", valid_out, 1);
    chk("rel_e2_data", data_out, 8'h11);
    chk("rel_e2_rptr", read_ptr_out, 1);
    chk("rel_e2_rgray", rptr_gray_out, 1);
    chk("rel_e2_count", rd_count_out, 1);
    ready_in = 1'b1;
    repeat (3) tick();
    chk("rel_drained", valid_out, 0);

    // Streaming 16 words with ready held high.
    for (int i = 0; i < 16; i++) write_word(WIDTH'(i));
    wait_valid();
    for (int i = 0; i < 16; i++) begin
      chk("stream_valid", valid_out, 1);
      tick();
    end
    chk("stream_end_valid", valid_out, 0);
    chk("stream_end_empty", empty_out, 1);

    // Backpressure: four words, consumer stalls for 10 cycles.
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) write_word(WIDTH'($urandom));
    b0 = exp_q[0];
    wait_valid();
    repeat (10) begin
      tick();
      chk("bp_hold_data", data_out, b0);
      chk("bp_hold_valid", valid_out, 1);
      chk("bp_no_pop", read_out, 0);
      chk("bp_count", rd_count_out, 3);
    end
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge r_clk);
      chk("bp_burst_valid", valid_out, 1);
    end
    tick();
    chk("bp_end_valid", valid_out, 0);
    chk("bp_end_empty", empty_out, 1);

    // Full memory, then a 40-word stream with random consumer stalls.
    ready_in = 1'b0;
    for (int i = 0; i < 16; i++) write_word(WIDTH'($urandom));
    wait_valid();
    write_word(WIDTH'($urandom));
    repeat (3) tick();
    chk("full_count", rd_count_out, 16);
    chk("full_empty", empty_out, 0);
    chk("full_no_pop", read_out, 0);
    n = 17;
    for (int c = 0; c < 600 && (n < 40 || exp_q.size() != 0); c++) begin
      tick();
      ready_in = ($urandom_range(3) != 0);
      if (n < 40 && (w - d) < DEPTH && $urandom_range(1) == 1) begin
        write_word(WIDTH'($urandom));
        n++;
      end
    end
    chk("wrap_all_written", n, 40);
    chk("wrap_drained", exp_q.size(), 0);
    chk("wrap_seen", int'(saw_wrap), 1);

    // Reset while a word is held and five more sit in memory.
    ready_in = 1'b1;
    repeat (2) tick();
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) write_word(WIDTH'($urandom));
    wait_valid();
    tick();
    chk("mid_count", rd_count_out, 5);
    chk("mid_valid", valid_out, 1);
    #2 r_rstn = 1'b0;
    #1;
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_rptr", read_ptr_out, 0);
    chk("mid_rst_rgray", rptr_gray_out, 0);
    chk("mid_rst_empty", empty_out, 1);
    chk("mid_rst_count", rd_count_out, 0);
    chk("mid_rst_read", read_out, 0);
    w = 0;
    d = 0;
    exp_q.delete();
    wptr_gray_in = '0;
    repeat (2) tick();
    r_rstn = 1'b1;
    tick();

    // Single word after reset behaves as after power-up.
    mem[0] = 8'hA5;
    write_word(8'hA5);
    tick();
    chk("one_e0_empty", empty_out, 1);
    tick();
    chk("one_e1_empty", empty_out, 0);
    chk("one_e1_valid", valid_out, 0);
    tick();
    chk("one_e2_valid", valid_out, 1);
    chk("one_e2_data", data_out, 8'hA5);
    chk("one_e2_rptr", read_ptr_out, 1);
    chk("one_e2_rgray", rptr_gray_out, 1);
    chk("one_e2_count", rd_count_out, 0);
    ready_in = 1'b1;
    repeat (2) tick();
    chk("one_done_valid", valid_out, 0);

    // Random traffic on both sides, then drain.
    for (int c = 0; c < 300; c++) begin
      tick();
      ready_in = ($urandom_range(3) != 0);
      if ((w - d) < DEPTH && $urandom_range(1) == 1) write_word(WIDTH'($urandom));
    end
    ready_in = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    chk("final_drained", exp_q.size(), 0);
    tick();
    chk("final_empty", empty_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the asynchronous circular FIFO, sitting in the read clock domain opposite the write-side controller and the shared FIFO memory. It synchronizes the Gray-coded write pointer into the read domain and derives the empty flag and fill level. It drives the memory read address and exports its own Gray-coded read pointer back to the write domain. It presents words to the consumer through a registered first-word-fall-through valid/ready stage.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 16: FIFO entries; must equal 2^(PTR_WIDTH-1).
- PTR_WIDTH, 5: pointer width; MSB is the wrap bit, low PTR_WIDTH-1 bits address memory.

- r_clk  in  1  read-domain clock; all state on rising edge.
- r_rstn  in  1  asynchronous, active-low reset.
- wptr_gray_in  in  PTR_WIDTH  Gray-coded write pointer from write domain (asynchronous to r_clk).
- data_read_in  in  WIDTH  memory read data, combinationally addressed by read_ptr_out.
- ready_in  in  1  consumer accepts data_out this cycle.
- read_ptr_out  out  PTR_WIDTH  binary read pointer; memory uses bits [PTR_WIDTH-2:0].
- rptr_gray_out  out  PTR_WIDTH  registered Gray read pointer for the write-domain synchronizer.
- read_out  out  1  memory pop strobe this cycle.
- empty_out  out  1  memory holds no unread word, as seen in the read domain.
- data_out  out  WIDTH  registered output word.
- valid_out  out  1  data_out holds a word.
- rd_count_out  out  PTR_WIDTH  words in memory, excluding the word held in data_out.

## Operation
- Synchronizer: two flops wq1, wq2 capture wptr_gray_in. No logic sits between them.
- wbin = gray-to-binary(wq2). rbin is the binary read pointer. rgray = rbin ^ (rbin >> 1), registered.
- empty_out = (rgray == wq2), combinational from registers.
- rd_count_out = (wbin - rbin) mod 2^PTR_WIDTH. Range 0..DEPTH; equals DEPTH when the MSBs differ and the low bits are equal.
- read_out = !empty_out && (!valid_out || ready_in).
- On read_out:
  - data_out <= data_read_in.
  - valid_out <= 1.
  - rbin <= rbin + 1, wrapping modulo 2^PTR_WIDTH.
  - rgray <= Gray(rbin + 1).
- If valid_out && ready_in && !read_out: valid_out <= 0. data_out keeps its last value.
- If valid_out && !ready_in: data_out and valid_out stay constant.
- Simultaneous accept and pop: the new word replaces the accepted one, and valid_out stays 1. This gives full throughput of 1 word per cycle.
- The block never pops when empty_out=1, whatever the state of ready_in.
- read_ptr_out = rbin.
- Reset values (async on r_rstn low), all zero: wq1, wq2, rbin, rgray, data_out, valid_out. This makes empty_out=1, rd_count_out=0, read_out=0.
- Reset mid-operation: outputs go to reset values immediately. The in-flight word is discarded. The write side must be reset together.

## Timing
- Write pointer latency: a wptr_gray_in change stable before edge E0 is captured in wq1 at E0 and in wq2 at E1. empty_out deasserts after E1. The pop occurs at E2, and valid_out=1 after E2. Total: 3 r_clk edges from input change to valid_out.
- Read pointer: rptr_gray_out changes after the pop edge. Exactly one bit toggles per increment, including on wrap from 2^PTR_WIDTH-1 to 0.
- empty_out is pessimistic: it can stay asserted up to 2 cycles after a write.
- The consumer handshake transfers on any edge with valid_out && ready_in.
- rd_count_out lags true occupancy by the synchronizer delay and never overstates it.

## Test plan
- Reset: assert r_rstn=0 mid-cycle -> all outputs 0 and empty_out=1 asynchronously. Hold wptr_gray_in=5'b00011 during reset -> no pop until 2 edges after release.
- Single word: memory addr 0 = 8'hA5, wptr_gray_in 0 -> 1 -> empty_out falls after 2 edges. valid_out=1 and data_out=8'hA5 after the 3rd edge. read_ptr_out=1, rptr_gray_out=5'b00001, rd_count_out=0.
- Streaming: 16 words 8'h00..8'h0F written, ready_in held 1 -> 16 consecutive cycles of valid_out=1 carrying 00..0F in order. Then valid_out=0 and empty_out=1.
- Backpressure: 4 words available, ready_in=0 for 10 cycles -> data_out holds word 0, read_out fires once only, rd_count_out=3. Releasing ready_in delivers words 1..3 back-to-back.
- Wrap-around: stream 40 words through a DEPTH=16 FIFO -> read_ptr_out wraps 31 -> 0. Every rptr_gray_out change is a 1-bit Hamming step. rd_count_out=16 when wq2 is 16 ahead.
- Reset mid-stream: r_rstn low while valid_out=1 and rd_count_out=5 -> valid_out=0, read_ptr_out=0 immediately. After release, behaviour is identical to first power-up.
